// File: rtl/arp_tx_engine_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : arp_tx_engine_pkg                                       |
// | Purpose  : Shared ARP/Ethernet constants, FSM types and byte-pick   |
// |            helpers for the ARP transmit path.                      |
// | Revision : 1.0  initial release                                    |
// +--------------------------------------------------------------------+
`ifndef SocketInUDPGP
`define SocketInUDPGP 4'd3
`endif

package arp_tx_engine_pkg;

  // Ethernet / ARP field values
  localparam logic [15:0] ARP_ETHERTYPE  = 16'h0806;
  localparam logic [15:0] ARP_HTYPE_ETH  = 16'h0001;
  localparam logic [15:0] ARP_PTYPE_IPV4 = 16'h0800;
  localparam logic [7:0]  ARP_HLEN       = 8'h06;
  localparam logic [7:0]  ARP_PLEN       = 8'h04;
  localparam logic [15:0] ARP_OP_REQ     = 16'h0001;
  localparam logic [15:0] ARP_OP_REP     = 16'h0002;

  // Frame is header + ARP body + zero pad, no FCS
  localparam int          ARP_FRAME_LEN  = 60;
  localparam logic [5:0]  ARP_LAST_IDX   = 6'(ARP_FRAME_LEN - 1);

  // Socket mode in which the destination is multicast and never resolved
  localparam logic [3:0]  SOCKET_IN_UDPGP = `SocketInUDPGP;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARB  = 2'd1,
    ST_SEND = 2'd2,
    ST_GAP  = 2'd3
  } arp_state_e;

  typedef enum logic {
    KIND_REQ = 1'b0,
    KIND_REP = 1'b1
  } arp_kind_e;

  // Everything the byte mux needs, frozen at frame selection time
  typedef struct packed {
    arp_kind_e   kind;
    logic [47:0] local_mac;
    logic [31:0] local_ip;
    logic [47:0] peer_mac;   // requester MAC for replies, unused for requests
    logic [31:0] peer_ip;    // TPA: requester IP or address being resolved
  } arp_frame_t;

  // Byte idx (0 = MSB) of a 48-bit MAC
  function automatic logic [7:0] mac_byte(input logic [47:0] mac, input logic [5:0] idx);
    return 8'((mac << {idx, 3'b000}) >> 40);
  endfunction

  // Byte idx (0 = MSB) of a 32-bit IPv4 address
  function automatic logic [7:0] ip_byte(input logic [31:0] ip, input logic [5:0] idx);
    return 8'((ip << {idx, 3'b000}) >> 24);
  endfunction

endpackage
`default_nettype wire

// File: rtl/arp_frame_mux.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : arp_frame_mux                                           |
// | Purpose  : Combinational byte selector for the 60-byte ARP frame,   |
// |            indexed by the transmit byte counter.                   |
// | Revision : 1.0  initial release                                    |
// +--------------------------------------------------------------------+
module arp_frame_mux
  import arp_tx_engine_pkg::*;
(
  input  logic        is_rep,
  input  logic [47:0] local_mac,
  input  logic [31:0] local_ip,
  input  logic [47:0] peer_mac,
  input  logic [31:0] peer_ip,
  input  logic [5:0]  cnt,
  output logic [7:0]  data
);

  // Map byte index to frame field; request and reply differ in dst MAC, OPER and THA
  always_comb begin
    data = 8'h00;
    case (cnt) inside
      [6'd0:6'd5]:   data = is_rep ? mac_byte(peer_mac, cnt) : 8'hFF;
      [6'd6:6'd11]:  data = mac_byte(local_mac, cnt - 6'd6);
      6'd12:         data = ARP_ETHERTYPE[15:8];
      6'd13:         data = ARP_ETHERTYPE[7:0];
      6'd14:         data = ARP_HTYPE_ETH[15:8];
      6'd15:         data = ARP_HTYPE_ETH[7:0];
      6'd16:         data = ARP_PTYPE_IPV4[15:8];
      6'd17:         data = ARP_PTYPE_IPV4[7:0];
      6'd18:         data = ARP_HLEN;
      6'd19:         data = ARP_PLEN;
      6'd20:         data = is_rep ? ARP_OP_REP[15:8] : ARP_OP_REQ[15:8];
      6'd21:         data = is_rep ? ARP_OP_REP[7:0] : ARP_OP_REQ[7:0];
      [6'd22:6'd27]: data = mac_byte(local_mac, cnt - 6'd22);
      [6'd28:6'd31]: data = ip_byte(local_ip, cnt - 6'd28);
      [6'd32:6'd37]: data = is_rep ? mac_byte(peer_mac, cnt - 6'd32) : 8'h00;
      [6'd38:6'd41]: data = ip_byte(peer_ip, cnt - 6'd38);
      default:       data = 8'h00;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/arp_tx_engine.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : arp_tx_engine                                           |
// | Purpose  : ARP frame transmitter. Answers ARP requests for our IP   |
// |            and periodically asks for SetDataDstIP while unresolved, |
// |            streaming 60-byte frames to the MAC TX arbiter.         |
// | Revision : 1.0  initial release                                    |
// +--------------------------------------------------------------------+
module arp_tx_engine
  import arp_tx_engine_pkg::*;
#(
  parameter int REQ_PERIOD = 125_000_000,
  parameter int TIMER_W    = 27
)(
  input  logic        clk,
  input  logic        rst,
  input  logic [47:0] SetLocalMAC,
  input  logic [31:0] SetLocalIP,
  input  logic [31:0] SetDataDstIP,
  input  logic [3:0]  SetWorkProtocol,
  input  logic        ARPReqReced,
  input  logic [47:0] RecSrcMacAddr,
  input  logic [31:0] RecSrcIP,
  input  logic        DstMacAddrRdy,
  output logic        ArpTxReq,
  input  logic        ArpTxGrant,
  output logic [7:0]  ArpTxData,
  output logic        ArpTxValid,
  output logic        ArpTxSof,
  output logic        ArpTxEof,
  input  logic        ArpTxReady
);

  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(REQ_PERIOD - 1);

  // FSM and frame registers
  arp_state_e   state_q, state_d;
  logic         req_q, req_d;
  logic         valid_q, valid_d;
  logic [5:0]   cnt_q, cnt_d;
  arp_frame_t   frame_q, frame_d;

  // Pending work, reply capture and request timer
  logic         rep_pend_q, rep_pend_d;
  logic         req_pend_q, req_pend_d;
  logic [47:0]  rep_mac_q, rep_mac_d;
  logic [31:0]  rep_ip_q, rep_ip_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [31:0]  dst_ip_prev_q, dst_ip_prev_d;

  logic         hold_off;
  logic         timer_wrap;
  logic         dst_change;
  logic         take_rep;
  logic         take_req;
  logic [7:0]   mux_data;

  // Requests are pointless once the MAC is known or in multicast mode
  assign hold_off   = DstMacAddrRdy | (SetWorkProtocol == SOCKET_IN_UDPGP);
  assign timer_wrap = !hold_off && (timer_q == TIMER_LAST);
  assign dst_change = !hold_off && (SetDataDstIP != dst_ip_prev_q);

  // IDLE picks a frame; a pending reply always goes first
  assign take_rep = (state_q == ST_IDLE) && rep_pend_q;
  assign take_req = (state_q == ST_IDLE) && !rep_pend_q && req_pend_q;

  // Pend flags and timer: a set in the same cycle as a clear wins
  always_comb begin
    timer_d       = hold_off ? '0 : (timer_wrap ? '0 : timer_q + 1'b1);
    dst_ip_prev_d = SetDataDstIP;
    rep_mac_d     = ARPReqReced ? RecSrcMacAddr : rep_mac_q;
    rep_ip_d      = ARPReqReced ? RecSrcIP : rep_ip_q;

    rep_pend_d = rep_pend_q;
    if (take_rep)    rep_pend_d = 1'b0;
    if (ARPReqReced) rep_pend_d = 1'b1;

    req_pend_d = req_pend_q;
    if (take_req || hold_off)      req_pend_d = 1'b0;
    if (timer_wrap || dst_change)  req_pend_d = 1'b1;
  end

  // Next-state logic for IDLE -> ARB -> SEND -> GAP -> IDLE
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    frame_d = frame_q;
    case (state_q)
      ST_IDLE: begin
        if (rep_pend_q || req_pend_q) begin
          state_d           = ST_ARB;
          req_d             = 1'b1;
          frame_d.kind      = rep_pend_q ? KIND_REP : KIND_REQ;
          frame_d.local_mac = SetLocalMAC;
          frame_d.local_ip  = SetLocalIP;
          frame_d.peer_mac  = rep_pend_q ? rep_mac_q : 48'h0;
          frame_d.peer_ip   = rep_pend_q ? rep_ip_q : SetDataDstIP;
        end
      end
      ST_ARB: begin
        if (ArpTxGrant) begin
          state_d = ST_SEND;
          valid_d = 1'b1;
          cnt_d   = 6'd0;
        end
      end
      ST_SEND: begin
        if (valid_q && ArpTxReady) begin
          if (cnt_q == ARP_LAST_IDX) begin
            state_d = ST_GAP;
            valid_d = 1'b0;
            req_d   = 1'b0;
            cnt_d   = 6'd0;
          end else begin
            cnt_d = cnt_q + 6'd1;
          end
        end
      end
      ST_GAP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        req_d   = 1'b0;
        valid_d = 1'b0;
        cnt_d   = 6'd0;
      end
    endcase
  end

  // FSM, output and snapshot registers; reset aborts any frame in flight
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      req_q   <= 1'b0;
      valid_q <= 1'b0;
      cnt_q   <= 6'd0;
      frame_q <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
      frame_q <= frame_d;
    end
  end

  // Pend/timer registers; a request is owed straight out of reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      rep_pend_q    <= 1'b0;
      req_pend_q    <= 1'b1;
      rep_mac_q     <= 48'h0;
      rep_ip_q      <= 32'h0;
      timer_q       <= '0;
      dst_ip_prev_q <= SetDataDstIP;
    end else begin
      rep_pend_q    <= rep_pend_d;
      req_pend_q    <= req_pend_d;
      rep_mac_q     <= rep_mac_d;
      rep_ip_q      <= rep_ip_d;
      timer_q       <= timer_d;
      dst_ip_prev_q <= dst_ip_prev_d;
    end
  end

  arp_frame_mux u_frame_mux (
    .is_rep    (frame_q.kind == KIND_REP),
    .local_mac (frame_q.local_mac),
    .local_ip  (frame_q.local_ip),
    .peer_mac  (frame_q.peer_mac),
    .peer_ip   (frame_q.peer_ip),
    .cnt       (cnt_q),
    .data      (mux_data)
  );

  assign ArpTxReq   = req_q;
  assign ArpTxValid = valid_q;
  assign ArpTxData  = valid_q ? mux_data : 8'h00;
  assign ArpTxSof   = valid_q && (cnt_q == 6'd0);
  assign ArpTxEof   = valid_q && (cnt_q == ARP_LAST_IDX);

endmodule
`default_nettype wire

// File: tb/tb_arp_tx_engine.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : tb_arp_tx_engine                                        |
// | Purpose  : Scoreboard bench for arp_tx_engine: expected frames are  |
// |            queued as stimulus is applied and popped per byte.      |
// | Revision : 1.0  initial release                                    |
// +--------------------------------------------------------------------+
module tb_arp_tx_engine;
  import arp_tx_engine_pkg::*;

  localparam int          PERIOD    = 100;
  localparam logic [47:0] LOCAL_MAC = 48'h02_00_00_AA_BB_CC;
  localparam logic [31:0] LOCAL_IP  = 32'hC0A8_0164;
  localparam logic [31:0] DST_IP_A  = 32'hC0A8_01C8;
  localparam logic [31:0] DST_IP_B  = 32'h0A00_0001;
  localparam logic [47:0] MAC_1     = 48'h00_11_22_33_44_55;
  localparam logic [31:0] IP_1      = 32'hC0A8_0105;
  localparam logic [47:0] MAC_2     = 48'hDE_AD_BE_EF_00_01;
  localparam logic [31:0] IP_2      = 32'h0A01_0203;
  localparam logic [47:0] MAC_3     = 48'h66_77_88_99_AA_BB;
  localparam logic [31:0] IP_3      = 32'hAC10_0007;
  localparam logic [47:0] MAC_4     = 48'h12_34_56_78_9A_BC;
  localparam logic [31:0] IP_4      = 32'h0102_0304;

  logic        clk = 1'b0;
  logic        rst;
  logic [47:0] SetLocalMAC;
  logic [31:0] SetLocalIP;
  logic [31:0] SetDataDstIP;
  logic [3:0]  SetWorkProtocol;
  logic        ARPReqReced;
  logic [47:0] RecSrcMacAddr;
  logic [31:0] RecSrcIP;
  logic        DstMacAddrRdy;
  logic        ArpTxReq;
  logic        ArpTxGrant;
  logic [7:0]  ArpTxData;
  logic        ArpTxValid;
  logic        ArpTxSof;
  logic        ArpTxEof;
  logic        ArpTxReady;

  typedef struct {
    logic [7:0] data;
    logic       sof;
    logic       eof;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   sof_count = 0;
  int   last_sof_cyc = -1;
  int   prev_sof_cyc = -1;
  int   last_eof_cyc = -1;
  int   last_gap = -1;
  int   acc_in_frame = 0;
  logic       stall_pend = 1'b0;
  logic [7:0] stall_data;
  logic       stall_sof;
  logic       stall_eof;

  arp_tx_engine #(.REQ_PERIOD(PERIOD), .TIMER_W(8)) dut (
    .clk             (clk),
    .rst             (rst),
    .SetLocalMAC     (SetLocalMAC),
    .SetLocalIP      (SetLocalIP),
    .SetDataDstIP    (SetDataDstIP),
    .SetWorkProtocol (SetWorkProtocol),
    .ARPReqReced     (ARPReqReced),
    .RecSrcMacAddr   (RecSrcMacAddr),
    .RecSrcIP        (RecSrcIP),
    .DstMacAddrRdy   (DstMacAddrRdy),
    .ArpTxReq        (ArpTxReq),
    .ArpTxGrant      (ArpTxGrant),
    .ArpTxData       (ArpTxData),
    .ArpTxValid      (ArpTxValid),
    .ArpTxSof        (ArpTxSof),
    .ArpTxEof        (ArpTxEof),
    .ArpTxReady      (ArpTxReady)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference frame builder: queues the 60 bytes an ARP request/reply must carry
  function automatic void push_frame(input bit is_rep, input logic [47:0] peer_mac,
                                     input logic [31:0] tpa);
    logic [7:0]  b [0:59];
    logic [47:0] lm;
    logic [31:0] li;
    exp_t        e;
    lm = LOCAL_MAC;
    li = LOCAL_IP;
    for (int i = 0; i < 60; i++) b[i] = 8'h00;
    for (int i = 0; i < 6; i++) begin
      b[i]      = is_rep ? peer_mac[47-8*i -: 8] : 8'hFF;
      b[6+i]    = lm[47-8*i -: 8];
      b[22+i]   = lm[47-8*i -: 8];
      b[32+i]   = is_rep ? peer_mac[47-8*i -: 8] : 8'h00;
    end
    b[12] = 8'h08; b[13] = 8'h06; b[14] = 8'h00; b[15] = 8'h01;
    b[16] = 8'h08; b[17] = 8'h00; b[18] = 8'h06; b[19] = 8'h04;
    b[20] = 8'h00; b[21] = is_rep ? 8'h02 : 8'h01;
    for (int i = 0; i < 4; i++) begin
      b[28+i] = li[31-8*i -: 8];
      b[38+i] = tpa[31-8*i -: 8];
    end
    for (int i = 0; i < 60; i++) begin
      e.data = b[i];
      e.sof  = (i == 0);
      e.eof  = (i == 59);
      exp_q.push_back(e);
    end
  endfunction

  // Byte monitor: pops the scoreboard on every accepted byte, checks stall stability
  always @(negedge clk) begin
    exp_t e;
    if (rst === 1'b1) begin
      if (stall_pend && ArpTxValid) begin
        checks++;
        if ({ArpTxData, ArpTxSof, ArpTxEof} !== {stall_data, stall_sof, stall_eof}) begin
          errors++;
          $display("FAIL stall_hold: data/sof/eof %h/%b/%b, required %h/%b/%b",
                   ArpTxData, ArpTxSof, ArpTxEof, stall_data, stall_sof, stall_eof);
        end
      end
      stall_pend = ArpTxValid && !ArpTxReady;
      stall_data = ArpTxData;
      stall_sof  = ArpTxSof;
      stall_eof  = ArpTxEof;
      if (ArpTxValid && ArpTxReady) begin
        if (ArpTxSof) begin
          prev_sof_cyc = last_sof_cyc;
          last_sof_cyc = cyc;
          last_gap     = cyc - last_eof_cyc;
          sof_count++;
        end
        if (ArpTxEof) last_eof_cyc = cyc;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_byte: got %h sof=%b eof=%b at cycle %0d, required no frame",
                   ArpTxData, ArpTxSof, ArpTxEof, cyc);
        end else begin
          e = exp_q.pop_front();
          if ({ArpTxData, ArpTxSof, ArpTxEof} !== {e.data, e.sof, e.eof}) begin
            errors++;
            $display("FAIL frame_byte[%0d]: data/sof/eof %h/%b/%b, required %h/%b/%b",
                     acc_in_frame, ArpTxData, ArpTxSof, ArpTxEof, e.data, e.sof, e.eof);
          end
        end
        acc_in_frame = ArpTxEof ? 0 : acc_in_frame + 1;
      end
    end else begin
      stall_pend   = 1'b0;
      acc_in_frame = 0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_pulse(input logic [47:0] mac, input logic [31:0] ip);
    ARPReqReced   = 1'b1;
    RecSrcMacAddr = mac;
    RecSrcIP      = ip;
    tick();
    ARPReqReced   = 1'b0;
  endtask

  task automatic wait_drain(input int limit, output bit timed_out);
    int n = 0;
    while (exp_q.size() != 0 && n < limit) begin
      tick();
      n++;
    end
    timed_out = (exp_q.size() != 0);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) tick();
    checks++;
    if ({ArpTxReq, ArpTxValid, ArpTxSof, ArpTxEof, ArpTxData} !== 12'h000) begin
      errors++;
      $display("FAIL reset_outputs: req/valid/sof/eof/data %b/%b/%b/%b/%h, required all 0",
               ArpTxReq, ArpTxValid, ArpTxSof, ArpTxEof, ArpTxData);
    end
    push_frame(1'b0, 48'h0, DST_IP_A);
    rst = 1'b1;
    tick();
    checks++;
    if ({ArpTxReq, ArpTxValid} !== 2'b10) begin
      errors++;
      $display("FAIL reset_first_req: req/valid %b/%b, required 1/0", ArpTxReq, ArpTxValid);
    end
    tick();
    checks++;
    if ({ArpTxValid, ArpTxSof} !== 2'b11) begin
      errors++;
      $display("FAIL reset_first_sof: valid/sof %b/%b, required 1/1", ArpTxValid, ArpTxSof);
    end
  endtask

  task automatic test_periodic_request();
    bit to;
    wait_drain(200, to);
    checks++;
    if (to !== 1'b0) begin
      errors++;
      $display("FAIL first_request_drain: %0d bytes left, required 0", exp_q.size());
    end
    push_frame(1'b0, 48'h0, DST_IP_A);
    wait_drain(300, to);
    checks++;
    if (to !== 1'b0) begin
      errors++;
      $display("FAIL second_request_drain: %0d bytes left, required 0", exp_q.size());
    end
    checks++;
    if (last_sof_cyc - prev_sof_cyc !== PERIOD) begin
      errors++;
      $display("FAIL request_period: sof interval %0d, required %0d",
               last_sof_cyc - prev_sof_cyc, PERIOD);
    end
  endtask

  task automatic test_collision();
    bit to;
    int target;
    target = last_sof_cyc + PERIOD - 3;
    while (cyc < target) tick();
    push_frame(1'b1, MAC_2, IP_2);
    push_frame(1'b0, 48'h0, DST_IP_A);
    send_pulse(MAC_2, IP_2);
    wait_drain(400, to);
    checks++;
    if (to !== 1'b0) begin
      errors++;
      $display("FAIL collision_drain: %0d bytes left, required 0", exp_q.size());
    end
    checks++;
    if (last_gap !== 4) begin
      errors++;
      $display("FAIL collision_gap: eof-to-sof %0d cycles, required 4", last_gap);
    end
    DstMacAddrRdy = 1'b1;
  endtask

  task automatic test_reply();
    bit to;
    int s0;
    s0 = sof_count;
    ArpTxGrant = 1'b0;
    push_frame(1'b1, MAC_1, IP_1);
    push_frame(1'b1, MAC_3, IP_3);
    send_pulse(MAC_1, IP_1);
    checks++;
    if (ArpTxReq !== 1'b0) begin
      errors++;
      $display("FAIL reply_latency_n1: req %b, required 0", ArpTxReq);
    end
    tick();
    checks++;
    if ({ArpTxReq, ArpTxValid} !== 2'b10) begin
      errors++;
      $display("FAIL reply_latency_n2: req/valid %b/%b, required 1/0", ArpTxReq, ArpTxValid);
    end
    send_pulse(MAC_4, IP_4);
    send_pulse(MAC_3, IP_3);
    repeat (3) tick();
    checks++;
    if ({ArpTxReq, ArpTxValid} !== 2'b10) begin
      errors++;
      $display("FAIL arb_hold: req/valid %b/%b, required 1/0", ArpTxReq, ArpTxValid);
    end
    ArpTxGrant = 1'b1;
    wait_drain(400, to);
    checks++;
    if (to !== 1'b0) begin
      errors++;
      $display("FAIL reply_drain: %0d bytes left, required 0", exp_q.size());
    end
    repeat (5) tick();
    checks++;
    if (sof_count - s0 !== 2) begin
      errors++;
      $display("FAIL reply_frame_count: %0d frames, required 2", sof_count - s0);
    end
  endtask

  task automatic test_ready_toggle();
    bit to;
    int n;
    push_frame(1'b1, MAC_2, IP_2);
    send_pulse(MAC_2, IP_2);
    n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      ArpTxReady = ~ArpTxReady;
      tick();
      n++;
    end
    ArpTxReady = 1'b1;
    to = (exp_q.size() != 0);
    checks++;
    if (to !== 1'b0) begin
      errors++;
      $display("FAIL toggle_drain: %0d bytes left, required 0", exp_q.size());
    end
    tick();
  endtask

  task automatic test_no_requests();
    bit to;
    int s0;
    s0 = sof_count;
    repeat (3 * PERIOD) tick();
    checks++;
    if (sof_count !== s0) begin
      errors++;
      $display("FAIL resolved_quiet: %0d frames, required 0", sof_count - s0);
    end
    SetWorkProtocol = SOCKET_IN_UDPGP;
    DstMacAddrRdy   = 1'b0;
    repeat (3 * PERIOD) tick();
    checks++;
    if (sof_count !== s0) begin
      errors++;
      $display("FAIL multicast_quiet: %0d frames, required 0", sof_count - s0);
    end
    push_frame(1'b1, MAC_1, IP_1);
    send_pulse(MAC_1, IP_1);
    wait_drain(200, to);
    checks++;
    if (to !== 1'b0 || sof_count !== s0 + 1) begin
      errors++;
      $display("FAIL multicast_reply: %0d bytes left, %0d frames, required 0 left and 1 frame",
               exp_q.size(), sof_count - s0);
    end
  endtask

  task automatic test_reset_mid_frame();
    bit to;
    int s0;
    int n;
    s0 = sof_count;
    SetWorkProtocol = 4'd0;
    SetDataDstIP    = DST_IP_B;
    push_frame(1'b0, 48'h0, DST_IP_B);
    n = 0;
    while (!(ArpTxValid && acc_in_frame == 20) && n < 100) begin
      tick();
      n++;
    end
    checks++;
    if (acc_in_frame !== 20) begin
      errors++;
      $display("FAIL dst_change_request: %0d bytes sent, required 20", acc_in_frame);
    end
    rst = 1'b0;
    exp_q.delete();
    tick();
    checks++;
    if ({ArpTxReq, ArpTxValid, ArpTxData} !== 10'h000) begin
      errors++;
      $display("FAIL abort_outputs: req/valid/data %b/%b/%h, required 0/0/00",
               ArpTxReq, ArpTxValid, ArpTxData);
    end
    tick();
    push_frame(1'b0, 48'h0, DST_IP_B);
    rst = 1'b1;
    wait_drain(200, to);
    checks++;
    if (to !== 1'b0 || sof_count !== s0 + 2) begin
      errors++;
      $display("FAIL restart_frame: %0d bytes left, %0d sofs, required 0 left and 2 sofs",
               exp_q.size(), sof_count - s0);
    end
    DstMacAddrRdy = 1'b1;
  endtask

  initial begin
    rst             = 1'b0;
    SetLocalMAC     = LOCAL_MAC;
    SetLocalIP      = LOCAL_IP;
    SetDataDstIP    = DST_IP_A;
    SetWorkProtocol = 4'd0;
    ARPReqReced     = 1'b0;
    RecSrcMacAddr   = 48'h0;
    RecSrcIP        = 32'h0;
    DstMacAddrRdy   = 1'b0;
    ArpTxGrant      = 1'b1;
    ArpTxReady      = 1'b1;
    #1;
    test_reset();
    test_periodic_request();
    test_collision();
    test_reply();
    test_ready_toggle();
    test_no_requests();
    test_reset_mid_frame();
    repeat (5) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
